// File: rtl/rx_ring_pkg.sv
// Shared types and helpers for the receive packet-buffer ring controller.
// Holds the write-side state encoding and the pointer-to-enable decode.
package rx_ring_pkg;

    localparam int RING_NUM_FIFOS = 4;
    localparam int RING_PTR_W     = 2;
    localparam int RING_CNT_W     = 3;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    function automatic logic [RING_NUM_FIFOS-1:0] onehot(input logic [RING_PTR_W-1:0] ptr);
        logic [RING_NUM_FIFOS-1:0] v;
        v      = '0;
        v[ptr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rx_ring_ptr.sv
// Wrap-around ring pointer; the ring size is a power of two, so the natural
// binary rollover provides the NUM_FIFOS-1 -> 0 wrap.
module rx_ring_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rx_fifo_ring_ctrl.sv
// Sequences the receive packet buffers as a ring between the Manchester decoder
// (writer) and the processor interface (reader), one packet per buffer.
module rx_fifo_ring_ctrl
    import rx_ring_pkg::*;
#(
    parameter int NUM_FIFOS = RING_NUM_FIFOS,
    parameter int PTR_W     = RING_PTR_W,
    parameter int CNT_W     = RING_CNT_W
) (
    input  logic                 clk16x,
    input  logic                 reset_n,
    input  logic                 wr_sop,
    input  logic                 wr_byte,
    input  logic                 wr_eop,
    input  logic                 wr_abort,
    input  logic                 rd_byte,
    input  logic                 rd_done,
    input  logic [NUM_FIFOS-1:0] rx_fifo_full,
    input  logic [NUM_FIFOS-1:0] rx_fifo_empty,
    output logic [NUM_FIFOS-1:0] irx_fifo_wr_en,
    output logic [NUM_FIFOS-1:0] irx_fifo_rd_en,
    output logic [NUM_FIFOS-1:0] fifo_rst,
    output logic [PTR_W-1:0]     readfifo_write_ptr,
    output logic [PTR_W-1:0]     readfifo_read_ptr,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 rx_packet_avail,
    output logic                 rx_fifo_overflow,
    output logic                 rx_fifo_underrun
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_FIFOS);

    wr_state_t              state_q, state_d;
    logic [CNT_W-1:0]       pkt_count_q, pkt_count_d;
    logic                   avail_q, avail_d;
    logic                   overflow_q, overflow_d;
    logic                   underrun_q, underrun_d;
    logic [NUM_FIFOS-1:0]   fifo_rst_q, fifo_rst_d;

    logic [PTR_W-1:0]       wp;
    logic [PTR_W-1:0]       rp;
    logic                   wp_inc;
    logic                   rp_inc;
    logic                   wr_go;
    logic                   wr_flush;
    logic                   wr_ovf;
    logic                   rd_go;
    logic                   rd_und;
    logic                   cnt_zero;
    logic                   cnt_full;

    assign cnt_zero = (pkt_count_q == '0);
    assign cnt_full = (pkt_count_q == CNT_MAX);

    rx_ring_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk16x),
        .rst_n (reset_n),
        .inc   (wp_inc),
        .ptr   (wp)
    );

    rx_ring_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk16x),
        .rst_n (reset_n),
        .inc   (rp_inc),
        .ptr   (rp)
    );

    // Write side: a new sop while filling kills the packet in progress.
    always_comb begin
        state_d  = state_q;
        wp_inc   = 1'b0;
        wr_go    = 1'b0;
        wr_flush = 1'b0;
        wr_ovf   = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (wr_sop) begin
                    if (cnt_full) begin
                        state_d = W_DROP;
                        wr_ovf  = 1'b1;
                    end else begin
                        state_d = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (wr_abort || wr_sop) begin
                    wr_flush = 1'b1;
                    state_d  = W_IDLE;
                end else if (wr_eop) begin
                    wp_inc  = 1'b1;
                    state_d = W_IDLE;
                end else if (wr_byte) begin
                    if (rx_fifo_full[wp]) begin
                        wr_ovf   = 1'b1;
                        wr_flush = 1'b1;
                        state_d  = W_DROP;
                    end else begin
                        wr_go = 1'b1;
                    end
                end
            end
            W_DROP: begin
                if (wr_eop || wr_abort) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Read side plus the shared count / flush / pulse bookkeeping.
    always_comb begin
        rd_go  = rd_byte && !cnt_zero && !rx_fifo_empty[rp];
        rp_inc = rd_done && !cnt_zero;
        rd_und = (rd_byte && !rd_go) || (rd_done && cnt_zero);

        pkt_count_d = pkt_count_q;
        if (wp_inc && !rp_inc) begin
            pkt_count_d = pkt_count_q + CNT_ONE;
        end else if (rp_inc && !wp_inc) begin
            pkt_count_d = pkt_count_q - CNT_ONE;
        end

        fifo_rst_d = '0;
        if (wr_flush) begin
            fifo_rst_d = fifo_rst_d | onehot(wp);
        end
        if (rp_inc) begin
            fifo_rst_d = fifo_rst_d | onehot(rp);
        end

        avail_d    = (pkt_count_d != '0);
        overflow_d = wr_ovf;
        underrun_d = rd_und;
    end

    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= W_IDLE;
            pkt_count_q <= '0;
            avail_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            fifo_rst_q  <= '1;
        end else begin
            state_q     <= state_d;
            pkt_count_q <= pkt_count_d;
            avail_q     <= avail_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            fifo_rst_q  <= fifo_rst_d;
        end
    end

    assign irx_fifo_wr_en     = wr_go ? onehot(wp) : '0;
    assign irx_fifo_rd_en     = rd_go ? onehot(rp) : '0;
    assign fifo_rst           = fifo_rst_q;
    assign readfifo_write_ptr = wp;
    assign readfifo_read_ptr  = rp;
    assign pkt_count          = pkt_count_q;
    assign rx_packet_avail    = avail_q;
    assign rx_fifo_overflow   = overflow_q;
    assign rx_fifo_underrun   = underrun_q;

endmodule

// File: tb/tb_rx_fifo_ring_ctrl.sv
// Scenario bench for rx_fifo_ring_ctrl: directed ring scenarios followed by a
// randomized run checked against a queue-based model of the packet ring.
module tb_rx_fifo_ring_ctrl;

    localparam int N = 4;

    logic       clk16x = 1'b0;
    logic       reset_n;
    logic       wr_sop, wr_byte, wr_eop, wr_abort, rd_byte, rd_done;
    logic [3:0] rx_fifo_full, rx_fifo_empty;
    logic [3:0] irx_fifo_wr_en, irx_fifo_rd_en, fifo_rst;
    logic [1:0] readfifo_write_ptr, readfifo_read_ptr;
    logic [2:0] pkt_count;
    logic       rx_packet_avail, rx_fifo_overflow, rx_fifo_underrun;

    int n_cmp = 0;
    int n_bad = 0;

    rx_fifo_ring_ctrl dut (
        .clk16x             (clk16x),
        .reset_n            (reset_n),
        .wr_sop             (wr_sop),
        .wr_byte            (wr_byte),
        .wr_eop             (wr_eop),
        .wr_abort           (wr_abort),
        .rd_byte            (rd_byte),
        .rd_done            (rd_done),
        .rx_fifo_full       (rx_fifo_full),
        .rx_fifo_empty      (rx_fifo_empty),
        .irx_fifo_wr_en     (irx_fifo_wr_en),
        .irx_fifo_rd_en     (irx_fifo_rd_en),
        .fifo_rst           (fifo_rst),
        .readfifo_write_ptr (readfifo_write_ptr),
        .readfifo_read_ptr  (readfifo_read_ptr),
        .pkt_count          (pkt_count),
        .rx_packet_avail    (rx_packet_avail),
        .rx_fifo_overflow   (rx_fifo_overflow),
        .rx_fifo_underrun   (rx_fifo_underrun)
    );

    always #5 clk16x = ~clk16x;

    task automatic tick();
        @(posedge clk16x);
        #1;
    endtask

    task automatic clr();
        wr_sop = 0; wr_byte = 0; wr_eop = 0; wr_abort = 0;
        rd_byte = 0; rd_done = 0;
        rx_fifo_full = '0; rx_fifo_empty = '0;
    endtask

    task automatic send_pkt(input int nbytes);
        wr_sop = 1; tick(); wr_sop = 0;
        for (int i = 0; i < nbytes; i++) begin
            wr_byte = 1; tick(); wr_byte = 0;
        end
        wr_eop = 1; tick(); wr_eop = 0;
    endtask

    task automatic do_reset();
        clr();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clr();
        reset_n = 0;
        tick(); tick();
        n_cmp++;
        if ({fifo_rst, readfifo_write_ptr, readfifo_read_ptr, pkt_count,
             rx_packet_avail, rx_fifo_overflow, rx_fifo_underrun} !== {4'b1111, 2'd0, 2'd0, 3'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: rst=%b wp=%0d rp=%0d cnt=%0d av/ov/un=%b%b%b want rst=1111 rest 0",
                     fifo_rst, readfifo_write_ptr, readfifo_read_ptr, pkt_count,
                     rx_packet_avail, rx_fifo_overflow, rx_fifo_underrun);
        end
        reset_n = 1;
        #1;
        n_cmp++;
        if (fifo_rst !== 4'b1111) begin
            n_bad++; $display("FAIL reset_release_hold: fifo_rst=%b want 1111", fifo_rst);
        end
        tick();
        n_cmp++;
        if (fifo_rst !== 4'b0000) begin
            n_bad++; $display("FAIL reset_first_edge: fifo_rst=%b want 0000", fifo_rst);
        end
    endtask

    task automatic test_single_packet();
        wr_sop = 1; #1;
        n_cmp++;
        if (irx_fifo_wr_en !== 4'b0000) begin
            n_bad++; $display("FAIL single_sop_wr_en: got %b want 0000", irx_fifo_wr_en);
        end
        tick(); wr_sop = 0;
        for (int i = 0; i < 3; i++) begin
            wr_byte = 1; #1;
            n_cmp++;
            if (irx_fifo_wr_en !== 4'b0001) begin
                n_bad++; $display("FAIL single_byte%0d_wr_en: got %b want 0001", i, irx_fifo_wr_en);
            end
            tick(); wr_byte = 0;
        end
        wr_eop = 1; tick(); wr_eop = 0;
        n_cmp++;
        if ({readfifo_write_ptr, readfifo_read_ptr, pkt_count, rx_packet_avail} !== {2'd1, 2'd0, 3'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL single_commit: wp=%0d rp=%0d cnt=%0d avail=%b want 1 0 1 1",
                     readfifo_write_ptr, readfifo_read_ptr, pkt_count, rx_packet_avail);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) send_pkt(2);
        n_cmp++;
        if ({readfifo_write_ptr, pkt_count} !== {2'd0, 3'd4}) begin
            n_bad++; $display("FAIL ovf_ring_full: wp=%0d cnt=%0d want 0 4", readfifo_write_ptr, pkt_count);
        end
        wr_sop = 1; tick(); wr_sop = 0;
        n_cmp++;
        if ({rx_fifo_overflow, readfifo_write_ptr, pkt_count} !== {1'b1, 2'd0, 3'd4}) begin
            n_bad++;
            $display("FAIL ovf_pulse: ovf=%b wp=%0d cnt=%0d want 1 0 4", rx_fifo_overflow, readfifo_write_ptr, pkt_count);
        end
        wr_byte = 1; #1;
        n_cmp++;
        if (irx_fifo_wr_en !== 4'b0000) begin
            n_bad++; $display("FAIL ovf_drop_wr_en: got %b want 0000", irx_fifo_wr_en);
        end
        tick(); wr_byte = 0;
        n_cmp++;
        if (rx_fifo_overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_single_cycle: ovf=%b want 0", rx_fifo_overflow);
        end
        wr_eop = 1; tick(); wr_eop = 0;
        n_cmp++;
        if ({readfifo_write_ptr, pkt_count} !== {2'd0, 3'd4}) begin
            n_bad++; $display("FAIL ovf_drop_eop: wp=%0d cnt=%0d want 0 4", readfifo_write_ptr, pkt_count);
        end
        rd_byte = 1; #1;
        n_cmp++;
        if (irx_fifo_rd_en !== 4'b0001) begin
            n_bad++; $display("FAIL ovf_rd_en: got %b want 0001", irx_fifo_rd_en);
        end
        tick(); rd_byte = 0;
        for (int k = 0; k < 4; k++) begin
            rd_done = 1; tick(); rd_done = 0;
            n_cmp++;
            if (fifo_rst !== (4'b0001 << k)) begin
                n_bad++; $display("FAIL drain%0d_fifo_rst: got %b want %b", k, fifo_rst, 4'b0001 << k);
            end
        end
        n_cmp++;
        if ({readfifo_read_ptr, pkt_count, rx_packet_avail} !== {2'd0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_done: rp=%0d cnt=%0d avail=%b want 0 0 0", readfifo_read_ptr, pkt_count, rx_packet_avail);
        end
    endtask

    task automatic test_abort();
        wr_sop = 1; tick(); wr_sop = 0;
        wr_byte = 1; tick(); tick(); wr_byte = 0;
        wr_abort = 1; tick(); wr_abort = 0;
        n_cmp++;
        if ({fifo_rst, readfifo_write_ptr, pkt_count} !== {4'b0001, 2'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL abort_flush: rst=%b wp=%0d cnt=%0d want 0001 0 0", fifo_rst, readfifo_write_ptr, pkt_count);
        end
        tick();
        n_cmp++;
        if (fifo_rst !== 4'b0000) begin
            n_bad++; $display("FAIL abort_flush_pulse: rst=%b want 0000", fifo_rst);
        end
        wr_sop = 1; tick(); wr_sop = 0;
        wr_byte = 1; #1;
        n_cmp++;
        if (irx_fifo_wr_en !== 4'b0001) begin
            n_bad++; $display("FAIL abort_reuse_wr_en: got %b want 0001", irx_fifo_wr_en);
        end
        tick(); wr_byte = 0;
        wr_eop = 1; tick(); wr_eop = 0;
    endtask

    task automatic test_simultaneous();
        rd_done = 1; tick(); rd_done = 0;
        send_pkt(1); send_pkt(1);
        rd_done = 1; tick(); tick(); rd_done = 0;
        send_pkt(1);
        n_cmp++;
        if ({readfifo_write_ptr, readfifo_read_ptr, pkt_count} !== {2'd0, 2'd3, 3'd1}) begin
            n_bad++;
            $display("FAIL simul_setup: wp=%0d rp=%0d cnt=%0d want 0 3 1", readfifo_write_ptr, readfifo_read_ptr, pkt_count);
        end
        wr_sop = 1; tick(); wr_sop = 0;
        wr_byte = 1; tick(); wr_byte = 0;
        wr_eop = 1; rd_done = 1; tick(); wr_eop = 0; rd_done = 0;
        n_cmp++;
        if ({readfifo_write_ptr, readfifo_read_ptr, pkt_count, fifo_rst} !== {2'd1, 2'd0, 3'd1, 4'b1000}) begin
            n_bad++;
            $display("FAIL simul_commit_read: wp=%0d rp=%0d cnt=%0d rst=%b want 1 0 1 1000",
                     readfifo_write_ptr, readfifo_read_ptr, pkt_count, fifo_rst);
        end
    endtask

    task automatic test_underrun();
        rd_done = 1; tick(); rd_done = 0;
        rd_byte = 1; #1;
        n_cmp++;
        if (irx_fifo_rd_en !== 4'b0000) begin
            n_bad++; $display("FAIL underrun_rd_en: got %b want 0000", irx_fifo_rd_en);
        end
        tick(); rd_byte = 0;
        n_cmp++;
        if ({rx_fifo_underrun, readfifo_read_ptr, pkt_count} !== {1'b1, 2'd1, 3'd0}) begin
            n_bad++;
            $display("FAIL underrun_byte: un=%b rp=%0d cnt=%0d want 1 1 0", rx_fifo_underrun, readfifo_read_ptr, pkt_count);
        end
        tick();
        n_cmp++;
        if (rx_fifo_underrun !== 1'b0) begin
            n_bad++; $display("FAIL underrun_pulse: un=%b want 0", rx_fifo_underrun);
        end
        rd_done = 1; tick(); rd_done = 0;
        n_cmp++;
        if ({rx_fifo_underrun, readfifo_read_ptr, pkt_count, fifo_rst} !== {1'b1, 2'd1, 3'd0, 4'b0000}) begin
            n_bad++;
            $display("FAIL underrun_done: un=%b rp=%0d cnt=%0d rst=%b want 1 1 0 0000",
                     rx_fifo_underrun, readfifo_read_ptr, pkt_count, fifo_rst);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pkt(2); send_pkt(2);
        wr_sop = 1; tick(); wr_sop = 0;
        wr_byte = 1;
        reset_n = 0; #1;
        n_cmp++;
        if ({irx_fifo_wr_en, fifo_rst, readfifo_write_ptr, readfifo_read_ptr, pkt_count,
             rx_packet_avail, rx_fifo_overflow, rx_fifo_underrun} !== {4'b0000, 4'b1111, 2'd0, 2'd0, 3'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL midreset_state: wr_en=%b rst=%b wp=%0d rp=%0d cnt=%0d av=%b",
                     irx_fifo_wr_en, fifo_rst, readfifo_write_ptr, readfifo_read_ptr, pkt_count, rx_packet_avail);
        end
        tick(); tick();
        clr();
        reset_n = 1; #1;
        n_cmp++;
        if (fifo_rst !== 4'b1111) begin
            n_bad++; $display("FAIL midreset_hold: rst=%b want 1111", fifo_rst);
        end
        tick();
        n_cmp++;
        if (fifo_rst !== 4'b0000) begin
            n_bad++; $display("FAIL midreset_release: rst=%b want 0000", fifo_rst);
        end
        wr_byte = 1; #1;
        n_cmp++;
        if (irx_fifo_wr_en !== 4'b0000) begin
            n_bad++; $display("FAIL midreset_packet_dropped: wr_en=%b want 0000", irx_fifo_wr_en);
        end
        tick(); clr();
    endtask

    task automatic test_random();
        int         ring[$];
        int         wbuf;
        bit         filling, dropping;
        int         rbuf;
        logic [3:0] e_wr, e_rd, e_rst;
        bit         e_ovf, e_und, commit, pop;
        do_reset();
        ring.delete();
        wbuf = 0; filling = 0; dropping = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_sop        = ($urandom_range(0, 99) < 10);
            wr_byte       = ($urandom_range(0, 99) < 45);
            wr_eop        = ($urandom_range(0, 99) < 12);
            wr_abort      = ($urandom_range(0, 99) < 3);
            rd_byte       = ($urandom_range(0, 99) < 30);
            rd_done       = ($urandom_range(0, 99) < 9);
            rx_fifo_full  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rx_fifo_empty = 4'($urandom) & 4'($urandom);

            rbuf = (wbuf - ring.size() + N) % N;
            e_wr = '0; e_rd = '0; e_rst = '0;
            e_ovf = 0; e_und = 0; commit = 0; pop = 0;
            if (filling) begin
                if (wr_abort || wr_sop) begin
                    e_rst[wbuf] = 1'b1; filling = 0;
                end else if (wr_eop) begin
                    commit = 1; filling = 0;
                end else if (wr_byte && rx_fifo_full[wbuf]) begin
                    e_ovf = 1; e_rst[wbuf] = 1'b1; filling = 0; dropping = 1;
                end else if (wr_byte) begin
                    e_wr[wbuf] = 1'b1;
                end
            end else if (dropping) begin
                if (wr_eop || wr_abort) dropping = 0;
            end else if (wr_sop) begin
                if (ring.size() == N) begin
                    e_ovf = 1; dropping = 1;
                end else begin
                    filling = 1;
                end
            end
            if (rd_byte) begin
                if (ring.size() != 0 && !rx_fifo_empty[rbuf]) e_rd[rbuf] = 1'b1;
                else e_und = 1;
            end
            if (rd_done) begin
                if (ring.size() != 0) begin
                    pop = 1; e_rst[rbuf] = 1'b1;
                end else begin
                    e_und = 1;
                end
            end

            #1;
            n_cmp++;
            if ({irx_fifo_wr_en, irx_fifo_rd_en} !== {e_wr, e_rd}) begin
                n_bad++;
                $display("FAIL rand_enables cyc %0d: wr=%b rd=%b want wr=%b rd=%b",
                         cyc, irx_fifo_wr_en, irx_fifo_rd_en, e_wr, e_rd);
            end

            if (pop) void'(ring.pop_front());
            if (commit) begin
                ring.push_back(wbuf);
                wbuf = (wbuf + 1) % N;
            end
            tick();
            rbuf = (wbuf - ring.size() + N) % N;
            n_cmp++;
            if ({readfifo_write_ptr, readfifo_read_ptr, pkt_count, rx_packet_avail, fifo_rst, rx_fifo_overflow, rx_fifo_underrun}
                !== {2'(wbuf), 2'(rbuf), 3'(ring.size()), ring.size() != 0, e_rst, e_ovf, e_und}) begin
                n_bad++;
                $display("FAIL rand_state cyc %0d: wp=%0d rp=%0d cnt=%0d av=%b rst=%b ov=%b un=%b want %0d %0d %0d %b %b %b %b",
                         cyc, readfifo_write_ptr, readfifo_read_ptr, pkt_count, rx_packet_avail, fifo_rst,
                         rx_fifo_overflow, rx_fifo_underrun, wbuf, rbuf, ring.size(), ring.size() != 0,
                         e_rst, e_ovf, e_und);
            end
        end
        clr();
    endtask

    initial begin
        clr();
        reset_n = 0;
        test_reset();
        test_single_packet();
        test_overflow();
        test_abort();
        test_simultaneous();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
